fft_stage_folded: RTL
=====================

// Module: fft_stage_folded
// PURPOSE
//  Time-multiplexed (folded) radix-2 FFT stage. It uses N_BFU butterflies per cycle instead of N_SAMPLES/2 parallel units.
//  It latches a full frame, walks it in G = N_SAMPLES/(2*N_BFU) compute cycles, then presents the frame with a val/rdy handshake.
//  It adds a per-frame inverse (conjugate-twiddle) mode and double buffering, so it accepts a new frame in the same cycle the
//  previous result drains. It is a drop-in for area-constrained FFT pipelines: chain log2(N_SAMPLES) instances, one per STAGE_FFT.
// PARAMETERS
//  BIT_WIDTH   32  signed fixed-point word width, real and imag
//  DECIMAL_PT  16  fractional bits
//  N_SAMPLES   8   frame length; power of 2, >= 4
//  STAGE_FFT   0   stage index; butterfly span = 2**STAGE_FFT; 0 <= STAGE_FFT < log2(N_SAMPLES)
//  N_BFU       1   butterflies per cycle; power of 2, divides N_SAMPLES/2
// PORTS
//  clk            in   1                     clock
//  reset          in   1                     asynchronous, active-high reset
//  recv_msg_real  in   BIT_WIDTH x N_SAMPLES input frame, real parts
//  recv_msg_imag  in   BIT_WIDTH x N_SAMPLES input frame, imag parts
//  recv_inverse   in   1                     1 = inverse mode for this frame; sampled with recv handshake
//  recv_val       in   1                     input frame valid
//  recv_rdy       out  1                     stage can accept a frame
//  send_msg_real  out  BIT_WIDTH x N_SAMPLES output frame, real parts
//  send_msg_imag  out  BIT_WIDTH x N_SAMPLES output frame, imag parts
//  send_val       out  1                     output frame valid
//  send_rdy       in   1                     downstream ready
//  sine_wave_in   in   BIT_WIDTH x N_SAMPLES sine_wave_in[i] = sin(2*pi*i/N_SAMPLES) in fixed point
// BEHAVIOUR
//  State machine: IDLE, COMPUTE, DONE. Group counter g is log2(G) bits; at least 1 bit when G=1.
//  Reset: state=IDLE, g=0, inv=0. Input and output buffers, send_msg_* = 0. send_val=0.
//   recv_rdy=0 while reset is asserted and 1 after release.
//   Reset mid-COMPUTE or mid-DONE discards the frame immediately.
//  recv_rdy = (state==IDLE) | (state==DONE & send_rdy). send_val = (state==DONE).
//  IDLE: on recv_val & recv_rdy, latch both arrays and recv_inverse into the input buffer. g<=0; go to COMPUTE.
//  COMPUTE: each edge processes butterflies b = g*N_BFU + k, k = 0..N_BFU-1, and writes both results into the output buffer.
//   It then increments g. The edge that processes g = G-1 moves to DONE. G edges total.
//  Pairing: span S = 2**STAGE_FFT; j = b % S; top = (b/S)*2*S + j; bot = top + S. Results are in place at indices top and bot.
//  Twiddle: IX = j*(N_SAMPLES/(2*S)); wr = sine_wave_in[(IX + N_SAMPLES/4) % N_SAMPLES]; wc = -sine_wave_in[IX].
//   Inverse mode uses wc = +sine_wave_in[IX].
//  Butterfly: t = w*b (complex). c = a + t -> top; d = a - t -> bot.
//  Arithmetic: each product is a full 2*BIT_WIDTH signed value; sum the two product terms, arithmetic shift right by DECIMAL_PT
//   (floor), keep the low BIT_WIDTH bits. All adds and subtracts wrap two's-complement; no saturation or scaling.
//  Latency: accept at edge E. send_val=1 from edge E+G until handshake. A new frame cannot be accepted before then.
//  DONE: send_msg_* and send_val are held stable while send_rdy=0.
//   send_val & send_rdy with recv_val=0: go to IDLE.
//   send_val & send_rdy with recv_val=1 in the same cycle: the output drains, the new frame latches, state goes to COMPUTE, g=0.
//   The output buffer is only overwritten on later COMPUTE edges.
//  recv_msg_* and recv_inverse are ignored outside the accepting handshake. sine_wave_in must be static between resets.
// TESTING
//  1. N=8, STAGE_FFT=0, N_BFU=1, real[0]=0x00010000, all else 0.
//     -> send_val after 4 edges; real[0]=real[1]=0x00010000; all else 0.
//  2. STAGE_FFT=1, real[3]=0x00010000, all else 0, forward (W=-j at b=1).
//     -> imag[1]=0xFFFF0000, imag[3]=0x00010000. With recv_inverse=1 the two signs swap.
//  3. Hold send_rdy=0 for 10 cycles in DONE -> send_val=1, data stable, recv_rdy=0.
//     Then assert send_rdy and recv_val together -> both handshakes fire; next frame out G edges later.
//  4. N_BFU=4, N=8 (G=1): back-to-back frames with send_rdy=1 -> one frame per 2 cycles, correct results.
//  5. Assert reset mid-COMPUTE -> send_val and outputs 0 without waiting for a clock edge; after release recv_rdy=1 and no stale frame appears.
//  6. Overflow at STAGE_FFT=0: a=b=0x7FFF0000 real -> top real=0xFFFE0000 (wrap), bot=0.
//     Plus 1000 random frames per (STAGE_FFT, N_BFU, inverse) checked bit-exact against the model.

Source files
------------

// File: rtl/fft_stage_folded.sv
// Folded radix-2 FFT stage: N_BFU butterflies per cycle over G compute cycles,
// with an input/output double buffer so a new frame can latch while the last one drains.
module fft_stage_folded #(
    parameter int unsigned BIT_WIDTH  = 32,
    parameter int unsigned DECIMAL_PT = 16,
    parameter int unsigned N_SAMPLES  = 8,
    parameter int unsigned STAGE_FFT  = 0,
    parameter int unsigned N_BFU      = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIT_WIDTH-1:0] recv_msg_real [N_SAMPLES],
    input  logic [BIT_WIDTH-1:0] recv_msg_imag [N_SAMPLES],
    input  logic                 recv_inverse,
    input  logic                 recv_val,
    output logic                 recv_rdy,
    output logic [BIT_WIDTH-1:0] send_msg_real [N_SAMPLES],
    output logic [BIT_WIDTH-1:0] send_msg_imag [N_SAMPLES],
    output logic                 send_val,
    input  logic                 send_rdy,
    input  logic [BIT_WIDTH-1:0] sine_wave_in  [N_SAMPLES]
);

    localparam int unsigned G       = N_SAMPLES / (2 * N_BFU);
    localparam int unsigned GW      = (G > 1) ? $clog2(G) : 1;
    localparam int unsigned IW      = $clog2(N_SAMPLES);
    localparam int unsigned S       = 1 << STAGE_FFT;
    localparam int unsigned TW_STEP = N_SAMPLES / (2 * S);

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t               state_q, state_d;
    logic [GW-1:0]        g_q, g_d;
    logic                 inv_q, inv_d;
    logic [BIT_WIDTH-1:0] in_real_q  [N_SAMPLES];
    logic [BIT_WIDTH-1:0] in_real_d  [N_SAMPLES];
    logic [BIT_WIDTH-1:0] in_imag_q  [N_SAMPLES];
    logic [BIT_WIDTH-1:0] in_imag_d  [N_SAMPLES];
    logic [BIT_WIDTH-1:0] out_real_q [N_SAMPLES];
    logic [BIT_WIDTH-1:0] out_real_d [N_SAMPLES];
    logic [BIT_WIDTH-1:0] out_imag_q [N_SAMPLES];
    logic [BIT_WIDTH-1:0] out_imag_d [N_SAMPLES];

    logic                 accept, compute_en, last_group;
    int unsigned          b, j, top, ix;
    logic [IW-1:0]        top_idx, bot_idx, cos_idx, sin_idx;
    logic [BIT_WIDTH-1:0] wr, wc, a_r, a_i, b_r, b_i, t_r, t_i;

    function automatic logic signed [2*BIT_WIDTH-1:0] sext(input logic [BIT_WIDTH-1:0] x);
        return {{BIT_WIDTH{x[BIT_WIDTH-1]}}, x};
    endfunction

    // x0*y0 -/+ x1*y1 at full product width, then floor-shifted back to BIT_WIDTH
    function automatic logic [BIT_WIDTH-1:0] fx_mac(
        input logic [BIT_WIDTH-1:0] x0,
        input logic [BIT_WIDTH-1:0] y0,
        input logic [BIT_WIDTH-1:0] x1,
        input logic [BIT_WIDTH-1:0] y1,
        input logic                 sub
    );
        logic signed [2*BIT_WIDTH-1:0] p0, p1, sum;
        p0  = sext(x0) * sext(y0);
        p1  = sext(x1) * sext(y1);
        sum = sub ? (p0 - p1) : (p0 + p1);
        return BIT_WIDTH'(sum >>> DECIMAL_PT);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = COMPUTE;
            COMPUTE: if (last_group) state_d = DONE;
            DONE:    if (send_rdy) state_d = accept ? COMPUTE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        recv_rdy   = 1'b0;
        send_val   = 1'b0;
        compute_en = 1'b0;
        case (state_q)
            IDLE:    recv_rdy = ~reset;
            COMPUTE: compute_en = 1'b1;
            DONE: begin
                send_val = 1'b1;
                recv_rdy = send_rdy & ~reset;
            end
            default: ;
        endcase
        accept     = recv_val & recv_rdy;
        last_group = (g_q == GW'(G - 1));
    end

    // Butterflies read the latched input frame and write in place into the output
    // buffer, so the previous result stays visible until the first compute edge.
    always_comb begin
        g_d        = g_q;
        inv_d      = inv_q;
        in_real_d  = in_real_q;
        in_imag_d  = in_imag_q;
        out_real_d = out_real_q;
        out_imag_d = out_imag_q;
        b = 0; j = 0; top = 0; ix = 0;
        top_idx = '0; bot_idx = '0; cos_idx = '0; sin_idx = '0;
        wr = '0; wc = '0; a_r = '0; a_i = '0; b_r = '0; b_i = '0; t_r = '0; t_i = '0;
        if (accept) begin
            in_real_d = recv_msg_real;
            in_imag_d = recv_msg_imag;
            inv_d     = recv_inverse;
            g_d       = '0;
        end else if (compute_en) begin
            g_d = last_group ? '0 : g_q + GW'(1);
            for (int unsigned k = 0; k < N_BFU; k++) begin
                b       = 32'(g_q) * N_BFU + k;
                j       = b % S;
                top     = (b / S) * 2 * S + j;
                ix      = j * TW_STEP;
                top_idx = IW'(top);
                bot_idx = IW'(top + S);
                cos_idx = IW'((ix + N_SAMPLES / 4) % N_SAMPLES);
                sin_idx = IW'(ix);
                wr      = sine_wave_in[cos_idx];
                wc      = inv_q ? sine_wave_in[sin_idx] : -sine_wave_in[sin_idx];
                a_r     = in_real_q[top_idx];
                a_i     = in_imag_q[top_idx];
                b_r     = in_real_q[bot_idx];
                b_i     = in_imag_q[bot_idx];
                t_r     = fx_mac(wr, b_r, wc, b_i, 1'b1);
                t_i     = fx_mac(wr, b_i, wc, b_r, 1'b0);
                out_real_d[top_idx] = a_r + t_r;
                out_imag_d[top_idx] = a_i + t_i;
                out_real_d[bot_idx] = a_r - t_r;
                out_imag_d[bot_idx] = a_i - t_i;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            g_q   <= '0;
            inv_q <= 1'b0;
            for (int unsigned i = 0; i < N_SAMPLES; i++) begin
                in_real_q[i]  <= '0;
                in_imag_q[i]  <= '0;
                out_real_q[i] <= '0;
                out_imag_q[i] <= '0;
            end
        end else begin
            g_q        <= g_d;
            inv_q      <= inv_d;
            in_real_q  <= in_real_d;
            in_imag_q  <= in_imag_d;
            out_real_q <= out_real_d;
            out_imag_q <= out_imag_d;
        end
    end

    always_comb begin
        send_msg_real = out_real_q;
        send_msg_imag = out_imag_q;
    end

endmodule
